// File: rtl/csr_access_arbiter.sv
// Two-port CSR access arbiter: picks core or clint, then serialises the access
// into read / modify / write / respond phases so read-modify-write is atomic.
module csr_access_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = 2
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        core_req_i,
  input  logic [1:0]  core_op_i,
  input  logic [11:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_gnt_o,
  output logic        core_done_o,
  output logic [31:0] core_rdata_o,

  input  logic        clint_req_i,
  input  logic [1:0]  clint_op_i,
  input  logic [11:0] clint_addr_i,
  input  logic [31:0] clint_wdata_i,
  output logic        clint_gnt_o,
  output logic        clint_done_o,
  output logic [31:0] clint_rdata_o,

  output logic [11:0] csr_raddr_o,
  input  logic [31:0] csr_rdata_i,
  output logic        csr_we_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int NPORT = 2;
  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  // Port 0 is the core, port 1 is the clint.
  logic [NPORT-1:0] req_vec;
  logic [NPORT-1:0] gnt_vec;
  logic [NPORT-1:0] done_vec;
  logic [1:0]       op_arr    [NPORT];
  logic [11:0]      addr_arr  [NPORT];
  logic [31:0]      wdata_arr [NPORT];
  logic [31:0]      rdata_arr [NPORT];

  assign req_vec      = {clint_req_i, core_req_i};
  assign op_arr[0]    = core_op_i;
  assign op_arr[1]    = clint_op_i;
  assign addr_arr[0]  = core_addr_i;
  assign addr_arr[1]  = clint_addr_i;
  assign wdata_arr[0] = core_wdata_i;
  assign wdata_arr[1] = clint_wdata_i;

  state_t           state_reg, state_next;
  logic             owner_reg, owner_next;
  logic [1:0]       op_reg, op_next;
  logic [11:0]      addr_reg, addr_next;
  logic [31:0]      wdata_reg, wdata_next;
  logic [31:0]      old_reg, old_next;
  logic [31:0]      new_reg, new_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic        any_req;
  logic        core_wins;
  logic        win_idx;
  logic        skip_write;
  logic [31:0] modify_val;

  // clint has priority unless the core has already lost STARVE_LIMIT times in a row.
  always_comb begin
    any_req   = |req_vec;
    core_wins = core_req_i & (~clint_req_i | (cnt_reg == LIMIT));
    win_idx   = ~core_wins;
  end

  always_comb begin
    modify_val = csr_rdata_i;
    case (op_reg)
      OP_WRITE: modify_val = wdata_reg;
      OP_SET:   modify_val = csr_rdata_i | wdata_reg;
      OP_CLEAR: modify_val = csr_rdata_i & ~wdata_reg;
      default:  modify_val = csr_rdata_i;
    endcase
    // A set/clear with an empty mask cannot change the register, so no write is issued.
    skip_write = (op_reg == OP_READ) ||
                 (((op_reg == OP_SET) || (op_reg == OP_CLEAR)) && (wdata_reg == 32'd0));
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    op_next    = op_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    old_next   = old_reg;
    new_next   = new_reg;
    cnt_next   = cnt_reg;
    gnt_vec    = '0;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          gnt_vec[0] = core_wins;
          gnt_vec[1] = ~core_wins;
          owner_next = win_idx;
          op_next    = op_arr[win_idx];
          addr_next  = addr_arr[win_idx];
          wdata_next = wdata_arr[win_idx];
          state_next = RD;
          if (core_wins) begin
            cnt_next = '0;
          end else if (core_req_i && (cnt_reg < LIMIT)) begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      RD: begin
        old_next   = csr_rdata_i;
        new_next   = modify_val;
        state_next = skip_write ? RESP : WR;
      end
      WR: begin
        state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      owner_reg <= 1'b0;
      op_reg    <= 2'b00;
      addr_reg  <= 12'd0;
      wdata_reg <= 32'd0;
      old_reg   <= 32'd0;
      new_reg   <= 32'd0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      op_reg    <= op_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      old_reg   <= old_next;
      new_reg   <= new_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign csr_raddr_o = (state_reg == RD) ? addr_reg : 12'd0;
  assign csr_we_o    = (state_reg == WR);
  assign csr_waddr_o = (state_reg == WR) ? addr_reg : 12'd0;
  assign csr_wdata_o = (state_reg == WR) ? new_reg : 32'd0;

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_resp
    assign done_vec[gi]  = (state_reg == RESP) && (owner_reg == 1'(gi));
    assign rdata_arr[gi] = done_vec[gi] ? old_reg : 32'd0;
  end

  assign core_gnt_o    = gnt_vec[0];
  assign clint_gnt_o   = gnt_vec[1];
  assign core_done_o   = done_vec[0];
  assign clint_done_o  = done_vec[1];
  assign core_rdata_o  = rdata_arr[0];
  assign clint_rdata_o = rdata_arr[1];

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Randomised bench for csr_access_arbiter: a transaction-level model tracks CSR
// contents and starvation state and predicts grants, writes and responses.
module tb_csr_access_arbiter;

  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_req_i = 1'b0;
  logic [1:0]  core_op_i = 2'b00;
  logic [11:0] core_addr_i = 12'd0;
  logic [31:0] core_wdata_i = 32'd0;
  logic        core_gnt_o, core_done_o;
  logic [31:0] core_rdata_o;
  logic        clint_req_i = 1'b0;
  logic [1:0]  clint_op_i = 2'b00;
  logic [11:0] clint_addr_i = 12'd0;
  logic [31:0] clint_wdata_i = 32'd0;
  logic        clint_gnt_o, clint_done_o;
  logic [31:0] clint_rdata_o;
  logic [11:0] csr_raddr_o, csr_waddr_o;
  logic [31:0] csr_rdata_i, csr_wdata_o;
  logic        csr_we_o;

  logic [31:0] csr_mem [4096];
  logic [31:0] ref_mem [4096];
  int          starve = 0;
  bit          last_core;
  int          checks = 0;
  int          errors = 0;
  int          txn_id = 0;

  csr_access_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .core_req_i(core_req_i), .core_op_i(core_op_i), .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i), .core_gnt_o(core_gnt_o), .core_done_o(core_done_o),
    .core_rdata_o(core_rdata_o),
    .clint_req_i(clint_req_i), .clint_op_i(clint_op_i), .clint_addr_i(clint_addr_i),
    .clint_wdata_i(clint_wdata_i), .clint_gnt_o(clint_gnt_o), .clint_done_o(clint_done_o),
    .clint_rdata_o(clint_rdata_o),
    .csr_raddr_o(csr_raddr_o), .csr_rdata_i(csr_rdata_i), .csr_we_o(csr_we_o),
    .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o)
  );

  always #5 clk = ~clk;

  // CSR register file: combinational read, write at the clock edge.
  assign csr_rdata_i = csr_mem[csr_raddr_o];
  always @(posedge clk) if (csr_we_o) csr_mem[csr_waddr_o] <= csr_wdata_o;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] v);
    csr_mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic do_txn(input bit c_on, input logic [1:0] c_op, input logic [11:0] c_addr,
                        input logic [31:0] c_wd, input bit k_on, input logic [1:0] k_op,
                        input logic [11:0] k_addr, input logic [31:0] k_wd,
                        input bit drop, input bit rst_wr);
    bit          exp_core, wr;
    logic [1:0]  op;
    logic [11:0] a;
    logic [31:0] wd, old_v, new_v;
    int          n;
    core_req_i = c_on;  core_op_i = c_op;  core_addr_i = c_addr;  core_wdata_i = c_wd;
    clint_req_i = k_on; clint_op_i = k_op; clint_addr_i = k_addr; clint_wdata_i = k_wd;
    #1;
    if (!c_on && !k_on) begin
      check("idle_core_gnt", core_gnt_o, 0);
      check("idle_clint_gnt", clint_gnt_o, 0);
      check("idle_raddr", csr_raddr_o, 0);
      tick();
      return;
    end
    n = 0;
    while (!(core_gnt_o || clint_gnt_o) && n < 8) begin
      tick();
      n++;
    end
    if (!(core_gnt_o || clint_gnt_o)) begin
      check("gnt_timeout", core_gnt_o | clint_gnt_o, 1);
      return;
    end
    exp_core = c_on && (!k_on || starve == LIMIT);
    check("gnt_core", core_gnt_o, exp_core);
    check("gnt_clint", clint_gnt_o, !exp_core);
    last_core = exp_core;
    if (exp_core) starve = 0;
    else if (c_on && starve < LIMIT) starve++;
    if (exp_core) begin op = c_op; a = c_addr; wd = c_wd; end
    else begin op = k_op; a = k_addr; wd = k_wd; end
    old_v = ref_mem[a];
    case (op)
      2'b00:   begin new_v = old_v;       wr = 1'b0;        end
      2'b01:   begin new_v = wd;          wr = 1'b1;        end
      2'b10:   begin new_v = old_v | wd;  wr = (wd != 0);   end
      default: begin new_v = old_v & ~wd; wr = (wd != 0);   end
    endcase

    tick();  // read phase
    if (drop) begin
      if (exp_core) begin core_req_i = 1'b0; core_wdata_i = ~core_wdata_i; end
      else begin clint_req_i = 1'b0; clint_wdata_i = ~clint_wdata_i; end
    end
    check("rd_raddr", csr_raddr_o, a);
    check("rd_we", csr_we_o, 0);
    check("rd_done", core_done_o | clint_done_o, 0);

    tick();
    if (wr) begin
      if (rst_wr) begin
        check("wr_we_pre_rst", csr_we_o, 1);
        rst = 1'b1;
        #1;
        check("rst_we", csr_we_o, 0);
        check("rst_waddr", csr_waddr_o, 0);
        check("rst_wdata", csr_wdata_o, 0);
        tick();
        check("rst_done", core_done_o | clint_done_o, 0);
        core_req_i = 1'b0;
        clint_req_i = 1'b0;
        rst = 1'b0;
        starve = 0;
        tick();
        check("rst_no_write", csr_mem[a], ref_mem[a]);
        check("rst_done2", core_done_o | clint_done_o, 0);
        txn_id++;
        $display("txn %0d aborted by reset: addr=%h", txn_id, a);
        return;
      end
      check("wr_we", csr_we_o, 1);
      check("wr_waddr", csr_waddr_o, a);
      check("wr_wdata", csr_wdata_o, new_v);
      check("wr_done", core_done_o | clint_done_o, 0);
      tick();
    end
    check("resp_we", csr_we_o, 0);
    check("resp_core_done", core_done_o, exp_core);
    check("resp_clint_done", clint_done_o, !exp_core);
    check("resp_core_rdata", core_rdata_o, exp_core ? old_v : 32'd0);
    check("resp_clint_rdata", clint_rdata_o, exp_core ? 32'd0 : old_v);
    check("resp_no_gnt", core_gnt_o | clint_gnt_o, 0);
    if (wr) ref_mem[a] = new_v;
    txn_id++;
    $display("txn %0d %s op=%0d addr=%h wd=%h old=%h new=%h wr=%0d",
             txn_id, exp_core ? "core " : "clint", op, a, wd, old_v, new_v, wr);
  endtask

  function automatic logic [11:0] pick_addr();
    case ($urandom_range(0, 4))
      0:       return 12'h300;
      1:       return 12'h305;
      2:       return 12'h341;
      3:       return 12'h342;
      default: return 12'($urandom_range(0, 4095));
    endcase
  endfunction

  function automatic logic [31:0] pick_data();
    if ($urandom_range(0, 3) == 0) return 32'd0;
    return $urandom;
  endfunction

  initial begin
    bit ord[5];
    ord = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4096; i++) begin
      logic [31:0] v;
      v = $urandom;
      csr_mem[i] = v;
      ref_mem[i] = v;
    end
    #2;
    check("reset_core_gnt", core_gnt_o, 0);
    check("reset_core_done", core_done_o, 0);
    check("reset_core_rdata", core_rdata_o, 0);
    check("reset_clint_done", clint_done_o, 0);
    check("reset_we", csr_we_o, 0);
    check("reset_raddr", csr_raddr_o, 0);
    check("reset_wdata", csr_wdata_o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Core read.
    preload(12'h305, 32'h8000_0100);
    do_txn(1, 2'b00, 12'h305, 32'h0, 0, 2'b00, 12'h0, 32'h0, 0, 0);
    // Clint set with a non-zero mask.
    preload(12'h342, 32'h0000_0003);
    do_txn(0, 2'b00, 12'h0, 32'h0, 1, 2'b10, 12'h342, 32'h0000_0008, 0, 0);
    check("set_result", csr_mem[12'h342], 32'h0000_000B);
    // Clear with an empty mask skips the write; then a real clear.
    do_txn(1, 2'b11, 12'h305, 32'h0, 0, 2'b00, 12'h0, 32'h0, 0, 0);
    preload(12'h305, 32'h1234_56FF);
    do_txn(1, 2'b11, 12'h305, 32'h0000_00FF, 0, 2'b00, 12'h0, 32'h0, 0, 0);
    check("clear_result", csr_mem[12'h305], 32'h1234_5600);
    // Request dropped and data changed after grant.
    do_txn(1, 2'b01, 12'h305, 32'hDEAD_BEEF, 0, 2'b00, 12'h0, 32'h0, 1, 0);
    check("drop_result", csr_mem[12'h305], 32'hDEAD_BEEF);

    // Both requesting continuously: starvation bound forces every fourth grant to the core.
    for (int i = 0; i < 5; i++) begin
      do_txn(1, 2'b00, 12'h300, 32'h0, 1, 2'b00, 12'h341, 32'h0, 0, 0);
      check("starve_order", last_core, ord[i]);
    end
    for (int i = 0; i < 2; i++) begin
      do_txn(1, 2'b00, 12'h300, 32'h0, 1, 2'b00, 12'h341, 32'h0, 0, 0);
      check("starve_fill", last_core, 0);
    end
    // Counter is saturated here; a reset during a clint write must clear it.
    do_txn(0, 2'b00, 12'h0, 32'h0, 1, 2'b01, 12'h342, 32'h0000_0055, 0, 1);
    do_txn(1, 2'b00, 12'h300, 32'h0, 1, 2'b00, 12'h341, 32'h0, 0, 0);
    check("post_rst_winner", last_core, 0);

    for (int i = 0; i < 200; i++) begin
      do_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), pick_addr(), pick_data(),
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), pick_addr(), pick_data(),
             ($urandom_range(0, 7) == 0), 0);
    end

    check("final_300", csr_mem[12'h300], ref_mem[12'h300]);
    check("final_305", csr_mem[12'h305], ref_mem[12'h305]);
    check("final_341", csr_mem[12'h341], ref_mem[12'h341]);
    check("final_342", csr_mem[12'h342], ref_mem[12'h342]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_access_arbiter.md
Name: csr_access_arbiter

Overview:
- Sits between two CSR requesters and the single shared CSR register file port: the execute stage (core port) and the interrupt controller (clint port).
- Arbitrates between the two and serialises each access into read, modify and write phases. This gives atomic CSR read/write/set/clear.
- Bounds core starvation with a wait counter.
- Downstream CSR read is combinational. Downstream write takes effect at the clock edge ending the cycle in which the write enable is high.

Parameters:
- STARVE_LIMIT, 3: consecutive arbitration losses by the core before the core is forced to win.
- CNT_W, 2: width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- core_req_i  in  1  core access request; held until core_gnt_o
- core_op_i  in  2  00 read, 01 write, 10 set, 11 clear
- core_addr_i  in  12  CSR address
- core_wdata_i  in  32  write data / set-clear mask
- core_gnt_o  out  1  request accepted (combinational, IDLE only)
- core_done_o  out  1  one-cycle completion pulse
- core_rdata_o  out  32  old CSR value; valid while core_done_o is high
- clint_req_i, clint_op_i, clint_addr_i, clint_wdata_i, clint_gnt_o, clint_done_o, clint_rdata_o: same as core set, for the clint port
- csr_raddr_o  out  12  CSR read address
- csr_rdata_i  in  32  CSR read data (combinational from csr_raddr_o)
- csr_we_o  out  1  CSR write enable
- csr_waddr_o  out  12  CSR write address
- csr_wdata_o  out  32  CSR write data

Behaviour:
- Reset (async, immediate):
  - state=IDLE, starvation counter=0, all latched fields=0.
  - All gnt/done/we outputs=0; all rdata/addr/wdata outputs=0.
  - Reset mid-transaction aborts it. No write occurs and no done pulse is issued.
- FSM states: IDLE, RD, WR, RESP.
- IDLE:
  - If any request is high, select a winner and raise that port's gnt in the same cycle.
  - Latch owner, op, addr and wdata, then go to RD.
  - With no request, stay in IDLE. All strobes are 0.
- Arbitration when both requests are high:
  - clint wins, unless the starvation counter equals STARVE_LIMIT; then the core wins.
  - The counter increments when the core loses with core_req_i high.
  - The counter clears when the core is granted.
  - The counter holds when core_req_i is low.
  - The counter saturates at STARVE_LIMIT.
  - A single requester wins immediately.
- RD:
  - csr_raddr_o = latched addr.
  - Register csr_rdata_i as old value.
  - Compute new value:
    - write: wdata
    - set: old | wdata
    - clear: old & ~wdata
  - Next state:
    - read op: RESP.
    - set/clear with wdata==0: RESP; the write is skipped.
    - otherwise: WR.
- WR:
  - csr_we_o=1 for exactly one cycle.
  - csr_waddr_o = latched addr; csr_wdata_o = new value.
  - Next state: RESP.
- RESP:
  - The owner's done=1 for one cycle; owner's rdata = old value.
  - Next state: IDLE. No grant is issued in RESP.
- Latency, counted from the grant cycle T:
  - Read, or skipped set/clear: done at T+2.
  - Write, or effective set/clear: we at T+2, done at T+3.
  - Peak throughput: one read per 3 cycles, one write per 4 cycles.
- Outputs outside their active state:
  - csr_raddr_o = latched addr in RD, 0 otherwise.
  - csr_we_o, csr_waddr_o, csr_wdata_o = 0 outside WR.
  - Non-owner done/rdata = 0. rdata_o = 0 when done is low.
- Mid-transaction rule: request or data changes after grant are ignored. The transaction completes with the latched values even if the request drops.
- A requester may re-request in its RESP cycle. It is considered in the following IDLE cycle.
- Illegal/unknown CSR addresses are passed through unchanged. Read data is whatever the CSR file returns.

Test Plan:
- Core read 0x305, csr_rdata_i=0x8000_0100
  -> core_gnt_o at T; csr_raddr_o=0x305 at T+1; core_done_o at T+2 with core_rdata_o=0x8000_0100; csr_we_o never high.
- Clint set 0x342 mask 0x0000_0008, old value 0x0000_0003
  -> csr_we_o at T+2 with waddr 0x342, wdata 0x0000_000B; clint_done_o at T+3 with clint_rdata_o=0x0000_0003.
- Core clear 0x305 mask 0x0000_0000
  -> no csr_we_o; core_done_o at T+2.
  Core clear 0x305 mask 0x0000_00FF, old value 0x1234_56FF
  -> csr_wdata_o=0x1234_5600.
- Both requests held continuously, STARVE_LIMIT=3
  -> grant order clint, clint, clint, core, clint...
  -> the counter reaches 3 and then clears on the core grant.
- Core write 0x305 data 0xDEAD_BEEF; core_req_i dropped and core_wdata_i changed after grant
  -> write still occurs with 0xDEAD_BEEF; core_done_o still pulses.
- Assert rst asynchronously in the WR cycle
  -> csr_we_o falls immediately; no done pulse.
  -> After release, the next request is granted from IDLE; the starvation counter is 0.
